rf_access_arbiter: RTL and testbench

Two-client access arbiter and sequencer for the 32x32 dual-read register file. Accepts read or write requests from the control unit (client 0) and the debug/loader port (client 1), grants one at a time with round-robin fairness, drives the register file's READ/WRITE/address/data pins for exactly one cycle per operation, and returns read data with a done pulse. It sits between the clients and the register file; no other block drives the register file pins.

---
 rtl/rf_access_arbiter_pkg.sv | 20 ++
 rtl/rf_access_arbiter_rr.sv | 17 +
 rtl/rf_access_arbiter.sv | 138 +++++++++++++
 tb/tb_rf_access_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_access_arbiter_pkg.sv
// Shared state encoding, default widths and client indices for rf_access_arbiter.
package rf_access_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    localparam logic CLIENT_CU  = 1'b0;
    localparam logic CLIENT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    function automatic logic [1:0] client_onehot(input logic idx);
        return (idx == CLIENT_DBG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rf_access_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the client named by pri_i.
module rr_arbiter_2
    import rf_access_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       pri_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = (pri_i == CLIENT_CU) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Two-client register-file access sequencer: IDLE -> ISSUE -> RESP per operation.
// Optional build macro RF_ZERO_PROTECT_EN suppresses writes to register 0.
module rf_access_arbiter
    import rf_access_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            REQ,
    input  logic [1:0]            WE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1_0,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1_1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2_0,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2_1,
    input  logic [ADDR_WIDTH-1:0] ADDR_W_0,
    input  logic [ADDR_WIDTH-1:0] ADDR_W_1,
    input  logic [DATA_WIDTH-1:0] DATA_W_0,
    input  logic [DATA_WIDTH-1:0] DATA_W_1,
    output logic [1:0]            GNT,
    output logic [1:0]            DONE,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic [DATA_WIDTH-1:0] RDATA2,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

    state_e                state_q, state_d;
    logic                  pri_q, pri_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_r1_q, addr_r1_d;
    logic [ADDR_WIDTH-1:0] addr_r2_q, addr_r2_d;
    logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;
    logic [1:0]            arb_gnt;
    logic                  sel;
    logic                  wr_allow;

    rr_arbiter_2 u_rr (
        .req_i (REQ),
        .pri_i (pri_q),
        .gnt_o (arb_gnt)
    );

    assign sel = arb_gnt[1];

`ifdef RF_ZERO_PROTECT_EN
    assign wr_allow = |addr_w_q;
`else
    assign wr_allow = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        pri_d     = pri_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_r1_d = addr_r1_q;
        addr_r2_d = addr_r2_q;
        addr_w_d  = addr_w_q;
        data_w_d  = data_w_q;
        rdata1_d  = rdata1_q;
        rdata2_d  = rdata2_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    state_d   = ST_ISSUE;
                    win_d     = sel;
                    pri_d     = ~sel;
                    we_d      = WE[sel];
                    addr_r1_d = sel ? ADDR_R1_1 : ADDR_R1_0;
                    addr_r2_d = sel ? ADDR_R2_1 : ADDR_R2_0;
                    addr_w_d  = sel ? ADDR_W_1  : ADDR_W_0;
                    data_w_d  = sel ? DATA_W_1  : DATA_W_0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
                // Read data is only valid while the pins are driven in ISSUE.
                if (!we_q) begin
                    rdata1_d = RF_DATA_R1;
                    rdata2_d = RF_DATA_R2;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            pri_q     <= CLIENT_CU;
            win_q     <= CLIENT_CU;
            we_q      <= 1'b0;
            addr_r1_q <= '0;
            addr_r2_q <= '0;
            addr_w_q  <= '0;
            data_w_q  <= '0;
            rdata1_q  <= '0;
            rdata2_q  <= '0;
        end else begin
            state_q   <= state_d;
            pri_q     <= pri_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_r1_q <= addr_r1_d;
            addr_r2_q <= addr_r2_d;
            addr_w_q  <= addr_w_d;
            data_w_q  <= data_w_d;
            rdata1_q  <= rdata1_d;
            rdata2_q  <= rdata2_d;
        end
    end

    // Strobes decode straight from the state register so a reset kills them at once.
    assign GNT        = (state_q == ST_ISSUE) ? client_onehot(win_q) : 2'b00;
    assign DONE       = (state_q == ST_RESP)  ? client_onehot(win_q) : 2'b00;
    assign RF_READ    = (state_q == ST_ISSUE) && !we_q;
    assign RF_WRITE   = (state_q == ST_ISSUE) && we_q && wr_allow;
    assign RF_ADDR_R1 = addr_r1_q;
    assign RF_ADDR_R2 = addr_r2_q;
    assign RF_ADDR_W  = addr_w_q;
    assign RF_DATA_W  = data_w_q;
    assign RDATA1     = rdata1_q;
    assign RDATA2     = rdata2_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: register-file model, transaction-level reference, directed scenarios.
module tb_rf_access_arbiter;

`ifdef RF_ZERO_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  REQ, WE;
    logic [4:0]  ADDR_R1_0, ADDR_R1_1, ADDR_R2_0, ADDR_R2_1, ADDR_W_0, ADDR_W_1;
    logic [31:0] DATA_W_0, DATA_W_1;
    logic [1:0]  GNT, DONE;
    logic [31:0] RDATA1, RDATA2;
    logic        RF_READ, RF_WRITE;
    logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
    logic [31:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    always #5 CLK = ~CLK;

    rf_access_arbiter dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE),
        .ADDR_R1_0(ADDR_R1_0), .ADDR_R1_1(ADDR_R1_1),
        .ADDR_R2_0(ADDR_R2_0), .ADDR_R2_1(ADDR_R2_1),
        .ADDR_W_0(ADDR_W_0), .ADDR_W_1(ADDR_W_1),
        .DATA_W_0(DATA_W_0), .DATA_W_1(DATA_W_1),
        .GNT(GNT), .DONE(DONE), .RDATA1(RDATA1), .RDATA2(RDATA2),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
        .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
    );

    // Register file driven only by the DUT pins; contents survive resets.
    logic [31:0] rf_mem [32];
    bit env_init;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            if (!env_init) begin
                for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h1000_0000 + i;
                env_init <= 1'b1;
            end
        end else if (RF_WRITE) begin
            rf_mem[RF_ADDR_W] <= RF_DATA_W;
        end
    end
    assign RF_DATA_R1 = rf_mem[RF_ADDR_R1];
    assign RF_DATA_R2 = rf_mem[RF_ADDR_R2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted op occupies a decision cycle, an issue cycle and a response cycle.
    int          cyc, m_issue, m_resp;
    bit          m_pri, m_win, m_we, m_init;
    logic [4:0]  m_a1, m_a2, m_aw;
    logic [31:0] m_dw, m_rd1, m_rd2;
    logic [31:0] m_rf [32];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc = 0; m_issue = -10; m_resp = -10;
            m_pri = 0; m_win = 0; m_we = 0;
            m_a1 = 0; m_a2 = 0; m_aw = 0; m_dw = 0; m_rd1 = 0; m_rd2 = 0;
            if (!m_init) begin
                for (int i = 0; i < 32; i++) m_rf[i] = 32'h1000_0000 + i;
                m_init = 1;
            end
        end else begin
            if (cyc == m_issue) begin
                if (m_we) begin
                    if (!(PROT && m_aw == 5'd0)) m_rf[m_aw] = m_dw;
                end else begin
                    m_rd1 = m_rf[m_a1];
                    m_rd2 = m_rf[m_a2];
                end
            end
            if (cyc > m_resp && REQ != 2'b00) begin
                m_win   = (REQ == 2'b11) ? m_pri : REQ[1];
                m_pri   = !m_win;
                m_we    = WE[m_win];
                m_a1    = m_win ? ADDR_R1_1 : ADDR_R1_0;
                m_a2    = m_win ? ADDR_R2_1 : ADDR_R2_0;
                m_aw    = m_win ? ADDR_W_1  : ADDR_W_0;
                m_dw    = m_win ? DATA_W_1  : DATA_W_0;
                m_issue = cyc + 1;
                m_resp  = cyc + 2;
            end
            cyc++;
        end
    end

    logic [1:0] e_one;
    always @(negedge CLK) begin
        if (started && !RST) begin
            e_one = m_win ? 2'b10 : 2'b01;
            check("m_gnt",   GNT,  (cyc == m_issue) ? e_one : 2'b00);
            check("m_done",  DONE, (cyc == m_resp)  ? e_one : 2'b00);
            check("m_rf_read",  RF_READ,  (cyc == m_issue) && !m_we);
            check("m_rf_write", RF_WRITE, (cyc == m_issue) && m_we && !(PROT && m_aw == 5'd0));
            check("m_addr_r1", RF_ADDR_R1, m_a1);
            check("m_addr_r2", RF_ADDR_R2, m_a2);
            check("m_addr_w",  RF_ADDR_W,  m_aw);
            check("m_data_w",  RF_DATA_W,  m_dw);
            check("m_rdata1",  RDATA1, m_rd1);
            check("m_rdata2",  RDATA2, m_rd2);
        end
    end

    task automatic do_reset(input bit chk);
        REQ = 2'b00;
        RST = 1'b1;
        @(negedge CLK);
        if (chk) begin
            check("rst_gnt", GNT, 2'b00);
            check("rst_done", DONE, 2'b00);
            check("rst_rdata1", RDATA1, 32'h0);
            check("rst_rdata2", RDATA2, 32'h0);
            check("rst_rf_ctl", {RF_READ, RF_WRITE}, 2'b00);
            check("rst_rf_addr", {RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W}, 15'h0);
            check("rst_rf_data", RF_DATA_W, 32'h0);
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_gnt(input int c, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (GNT[c]) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1'b1);
    endtask

    logic [1:0] gnt_log [13];
    logic [1:0] gacc;

    initial begin
        REQ = 0; WE = 0;
        ADDR_R1_0 = 0; ADDR_R1_1 = 0; ADDR_R2_0 = 0; ADDR_R2_1 = 0;
        ADDR_W_0 = 0; ADDR_W_1 = 0; DATA_W_0 = 0; DATA_W_1 = 0;
        #1;
        do_reset(1'b1);
        started = 1'b1;

        // Client 0 writes 0xDEADBEEF to register 5.
        WE = 2'b01; ADDR_W_0 = 5'd5; DATA_W_0 = 32'hDEAD_BEEF; REQ = 2'b01;
        @(negedge CLK);
        check("a_gnt", GNT, 2'b01);
        check("a_rf_write", RF_WRITE, 1'b1);
        check("a_rf_read", RF_READ, 1'b0);
        check("a_addr_w", RF_ADDR_W, 5'd5);
        check("a_data_w", RF_DATA_W, 32'hDEAD_BEEF);
        @(negedge CLK);
        check("a_done", DONE, 2'b01);
        check("a_write_off", RF_WRITE, 1'b0);
        REQ = 2'b00;

        // Client 1 reads registers 5 and 0, raised during RESP so it waits one idle cycle.
        WE = 2'b00; ADDR_R1_1 = 5'd5; ADDR_R2_1 = 5'd0; REQ = 2'b10;
        wait_gnt(1, "b_gnt_seen");
        check("b_gnt_cycle", cyc, 4);
        @(negedge CLK);
        check("b_done", DONE, 2'b10);
        check("b_rdata1", RDATA1, 32'hDEAD_BEEF);
        check("b_rdata2", RDATA2, 32'h1000_0000);
        REQ = 2'b00;

        // Both clients saturate: client 0 writes reg 7, client 1 reads it back.
        do_reset(1'b0);
        WE = 2'b01; ADDR_W_0 = 5'd7; DATA_W_0 = 32'hA5A5_0007;
        ADDR_R1_1 = 5'd7; ADDR_R2_1 = 5'd5; REQ = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            gnt_log[i] = GNT;
        end
        REQ = 2'b00;
        check("c_gnt1", gnt_log[1], 2'b01);
        check("c_gnt4", gnt_log[4], 2'b10);
        check("c_gnt7", gnt_log[7], 2'b01);
        check("c_gnt10", gnt_log[10], 2'b10);
        check("c_gnt_gaps", gnt_log[2] | gnt_log[3] | gnt_log[5] | gnt_log[6] | gnt_log[8]
                          | gnt_log[9] | gnt_log[11] | gnt_log[12], 2'b00);
        repeat (2) @(negedge CLK);
        check("c_rdata1", RDATA1, 32'hA5A5_0007);
        check("c_rdata2", RDATA2, 32'hDEAD_BEEF);

        // Reset lands in the middle of a write's ISSUE cycle.
        do_reset(1'b0);
        WE = 2'b01; ADDR_W_0 = 5'd9; DATA_W_0 = 32'h1234_5678; REQ = 2'b01;
        @(negedge CLK);
        check("d_write_issue", RF_WRITE, 1'b1);
        RST = 1'b1;
        #1;
        check("d_write_async", RF_WRITE, 1'b0);
        check("d_gnt", GNT, 2'b00);
        check("d_addr_w", RF_ADDR_W, 5'd0);
        check("d_data_w", RF_DATA_W, 32'h0);
        REQ = 2'b00;
        repeat (2) @(negedge CLK);
        check("d_no_done", DONE, 2'b00);
        check("d_mem9", rf_mem[9], 32'h1000_0009);
        RST = 1'b0;

        // Write of 1 to register 0, then read it back alongside reg 9.
        WE = 2'b10; ADDR_W_1 = 5'd0; DATA_W_1 = 32'h1; REQ = 2'b10;
        wait_gnt(1, "e_gnt_seen");
        check("e_rf_write", RF_WRITE, PROT ? 1'b0 : 1'b1);
        @(negedge CLK);
        check("e_done", DONE, 2'b10);
        REQ = 2'b00;
        WE = 2'b00; ADDR_R1_0 = 5'd0; ADDR_R2_0 = 5'd9; REQ = 2'b01;
        wait_gnt(0, "e_rd_gnt_seen");
        @(negedge CLK);
        check("e_rd_done", DONE, 2'b01);
        check("e_rdata_reg0", RDATA1, PROT ? 32'h1000_0000 : 32'h1);
        check("e_rdata_reg9", RDATA2, 32'h1000_0009);
        REQ = 2'b00;

        // Client 0 drops REQ during its own ISSUE cycle.
        ADDR_R1_0 = 5'd3; ADDR_R2_0 = 5'd4; WE = 2'b00; REQ = 2'b01;
        wait_gnt(0, "f_gnt_seen");
        REQ = 2'b00;
        @(negedge CLK);
        check("f_done", DONE, 2'b01);
        check("f_rdata1", RDATA1, 32'h1000_0003);
        check("f_rdata2", RDATA2, 32'h1000_0004);
        gacc = 2'b00;
        repeat (4) begin
            @(negedge CLK);
            gacc = gacc | GNT;
        end
        check("f_no_regrant", gacc, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
